// File: rtl/array_div_sequential.sv
// array_div_sequential
//   Sequential restoring divider on the TinyTapeout pinout. Each CALC cycle
//   resolves one quotient bit. Operands come in on ui_in; the result goes out
//   on uo_out as {remainder, quotient}. The handshake is start/busy/done on uio.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   ui_in    [WIDTH-1:0] dividend, [WIDTH+3:4] divisor
//   uo_out   [WIDTH-1:0] quotient, [WIDTH+3:4] remainder (unused bits 0)
//   uio_in   [0] start (level, sampled in IDLE); other bits ignored
//   uio_out  [1] busy, [2] done, [3] div_by_zero; other bits 0
//   uio_oe   constant 8'b0000_1110
//   ena      ignored
//
// Configuration macro
//   DIV_STICKY_DONE_EN  defined: done stays high until the next accepted start.
//                       undefined: done is a one-cycle pulse.
//
// state | meaning
// IDLE  | waiting for start; uo_out holds the last result
// CALC  | one restoring shift/subtract step per cycle, WIDTH steps
// DONE  | publish the result; busy drops and done rises on the exit edge

module array_div_sequential #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       uo_q, uo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             hold_q, hold_d;

  logic             start;
  logic [WIDTH-1:0] dividend, divisor;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH+1:0] trial;
  logic [7:0]       result;

  assign start    = uio_in[0];
  assign dividend = ui_in[WIDTH-1:0];
  assign divisor  = ui_in[WIDTH+3:4];

  // Shift {R,Q} left by one, then trial-subtract D; the extra top bit of
  // trial is the borrow that decides restore vs. keep.
  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign q_shift = q_q << 1;
  assign trial   = {1'b0, r_shift} - {2'b00, d_q};

  always_comb begin
    result = '0;
    result[WIDTH-1:0] = q_q;
    result[WIDTH+3:4] = r_q[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    uo_d    = uo_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    hold_d  = hold_q;
`ifdef DIV_STICKY_DONE_EN
    done_d  = done_q;
`else
    done_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          done_d = 1'b0;
          if (divisor == '0) begin
            q_d     = '1;
            r_d     = {1'b0, dividend};
            dbz_d   = 1'b1;
            // Divide-by-zero lingers one extra cycle in DONE so its done
            // edge lands two clocks after the accepting edge.
            hold_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = dividend;
            d_d     = divisor;
            r_d     = '0;
            cnt_d   = 3'(WIDTH);
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (trial[WIDTH+1]) begin
          r_d = r_shift;
          q_d = q_shift;
        end else begin
          r_d = trial[WIDTH:0];
          q_d = q_shift | WIDTH'(1);
        end
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_DONE;
      end

      S_DONE: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          uo_d    = result;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      uo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      uo_q    <= uo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hold_q  <= hold_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {4'b0000, dbz_q, done_q, busy_q, 1'b0};
  assign uio_oe  = 8'b0000_1110;

  // R's top bit is only a working guard bit; ena and the upper uio_in bits
  // have no function.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:1], ui_in, r_q[WIDTH]};

endmodule

// File: tb/tb_array_div_sequential.sv
module tb_array_div_sequential;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic       ena;

  int n_checks = 0;
  int n_pass   = 0;

  array_div_sequential #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division; divide-by-zero gives q=all ones, r=dividend.
  function automatic logic [7:0] model(input int a, input int b);
    if (b == 0) return 8'((a << 4) | 15);
    return 8'(((a % b) << 4) | (a / b));
  endfunction

  // Drive start for exactly one rising edge (edge N); returns at the negedge after N.
  task automatic launch(input int a, input int b);
    @(negedge clk);
    ui_in     = 8'(((b & 15) << 4) | (a & 15));
    uio_in[0] = 1'b1;
    @(negedge clk);
    uio_in[0] = 1'b0;
  endtask

  // k = number of edges after N until done is seen (99 on timeout);
  // busy_n = samples with busy high, counting the one just after N.
  task automatic wait_done(output int k, output int busy_n);
    busy_n = uio_out[1] ? 1 : 0;
    k = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (uio_out[1]) busy_n++;
      if (uio_out[2]) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ui_in = 8'h00; uio_in = 8'h00; ena = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (uo_out !== 8'h00) $display("FAIL reset_uo: got %h expected 00", uo_out); else n_pass++;
    n_checks++; if (uio_out !== 8'h00) $display("FAIL reset_uio_out: got %h expected 00", uio_out); else n_pass++;
    n_checks++; if (uio_oe !== 8'h0E) $display("FAIL reset_uio_oe: got %h expected 0e", uio_oe); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int k, bn;
    launch(13, 3);
    wait_done(k, bn);
    n_checks++; if (k !== 5) $display("FAIL basic_latency: got %0d expected 5", k); else n_pass++;
    n_checks++; if (bn !== 5) $display("FAIL basic_busy_cycles: got %0d expected 5", bn); else n_pass++;
    n_checks++; if (uo_out !== 8'h14) $display("FAIL basic_result: got %h expected 14", uo_out); else n_pass++;
    n_checks++; if (uio_out[3] !== 1'b0) $display("FAIL basic_dbz: got %b expected 0", uio_out[3]); else n_pass++;
  endtask

  task automatic test_edges;
    int k, bn;
    launch(15, 1);
    wait_done(k, bn);
    n_checks++; if (uo_out !== 8'h0F) $display("FAIL edge_15_1: got %h expected 0f", uo_out); else n_pass++;
    launch(0, 15);
    wait_done(k, bn);
    n_checks++; if (uo_out !== 8'h00) $display("FAIL edge_0_15: got %h expected 00", uo_out); else n_pass++;
    n_checks++; if (k !== 5) $display("FAIL edge_0_15_latency: got %0d expected 5", k); else n_pass++;
  endtask

  task automatic test_div_zero;
    int k, bn;
    launch(7, 0);
    wait_done(k, bn);
    n_checks++; if (k !== 2) $display("FAIL dbz_latency: got %0d expected 2", k); else n_pass++;
    n_checks++; if (bn !== 2) $display("FAIL dbz_busy_cycles: got %0d expected 2", bn); else n_pass++;
    n_checks++; if (uo_out !== 8'h7F) $display("FAIL dbz_result: got %h expected 7f", uo_out); else n_pass++;
    n_checks++; if (uio_out[3] !== 1'b1) $display("FAIL dbz_flag: got %b expected 1", uio_out[3]); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (uio_out[3] !== 1'b1) $display("FAIL dbz_flag_hold: got %b expected 1", uio_out[3]); else n_pass++;
    launch(9, 2);
    n_checks++; if (uio_out[3] !== 1'b0) $display("FAIL dbz_clear_on_accept: got %b expected 0", uio_out[3]); else n_pass++;
    wait_done(k, bn);
    n_checks++; if (uo_out !== 8'h14) $display("FAIL dbz_next_result: got %h expected 14", uo_out); else n_pass++;
  endtask

  task automatic test_ignore_start;
    int k, bn, rises;
    logic prev;
    launch(13, 3);
    @(negedge clk);
    ui_in = {4'd2, 4'd9};
    uio_in[0] = 1'b1;
    @(negedge clk);
    uio_in[0] = 1'b0;
    wait_done(k, bn);
    n_checks++; if (k !== 3) $display("FAIL ignore_latency: got %0d expected 3", k); else n_pass++;
    n_checks++; if (uo_out !== 8'h14) $display("FAIL ignore_result: got %h expected 14", uo_out); else n_pass++;
    rises = 0;
    prev = uio_out[2];
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (uio_out[2] && !prev) rises++;
      prev = uio_out[2];
    end
    n_checks++; if (rises !== 0) $display("FAIL ignore_second_done: got %0d expected 0", rises); else n_pass++;
    n_checks++; if (uo_out !== 8'h14) $display("FAIL ignore_hold: got %h expected 14", uo_out); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int k, bn;
    launch(13, 3);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (uo_out !== 8'h00) $display("FAIL midrst_uo: got %h expected 00", uo_out); else n_pass++;
    n_checks++; if (uio_out !== 8'h00) $display("FAIL midrst_uio_out: got %h expected 00", uio_out); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (uio_out[2] !== 1'b0) $display("FAIL midrst_no_done: got %b expected 0", uio_out[2]); else n_pass++;
    launch(14, 4);
    wait_done(k, bn);
    n_checks++; if (k !== 5) $display("FAIL midrst_latency: got %0d expected 5", k); else n_pass++;
    n_checks++; if (uo_out !== 8'h23) $display("FAIL midrst_result: got %h expected 23", uo_out); else n_pass++;
  endtask

  task automatic test_done_width;
    int k, bn, hi;
    launch(9, 2);
    wait_done(k, bn);
    n_checks++; if (k !== 5) $display("FAIL donew_latency: got %0d expected 5", k); else n_pass++;
`ifdef DIV_STICKY_DONE_EN
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uio_out[2]) hi++;
    end
    n_checks++; if (hi !== 10) $display("FAIL donew_sticky: got %0d expected 10", hi); else n_pass++;
    launch(9, 2);
    n_checks++; if (uio_out[2] !== 1'b0) $display("FAIL donew_sticky_clear: got %b expected 0", uio_out[2]); else n_pass++;
    wait_done(k, bn);
`else
    hi = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uio_out[2]) hi++;
    end
    n_checks++; if (hi !== 1) $display("FAIL donew_pulse: got %0d high cycles expected 1", hi); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back;
    int a[8], b[8];
    int k, bn;
    for (int i = 0; i < 8; i++) begin
      a[i] = $urandom_range(0, 15);
      b[i] = $urandom_range(1, 15);
    end
    @(negedge clk);
    ui_in = 8'((b[0] << 4) | a[0]);
    uio_in[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      wait_done(k, bn);
      n_checks++; if (k !== 5) $display("FAIL b2b_latency[%0d]: got %0d expected 5", i, k); else n_pass++;
      n_checks++; if (uo_out !== model(a[i], b[i]))
        $display("FAIL b2b_result[%0d] %0d/%0d: got %h expected %h", i, a[i], b[i], uo_out, model(a[i], b[i]));
      else n_pass++;
      if (i < 7) ui_in = 8'((b[i+1] << 4) | a[i+1]);
      else uio_in[0] = 1'b0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random;
    int a, b, k, bn, exp_k;
    for (int i = 0; i < 256; i++) begin
      a = $urandom_range(0, 15);
      b = (i < 16) ? 0 : $urandom_range(0, 15);
      launch(a, b);
      wait_done(k, bn);
      exp_k = (b == 0) ? 2 : 5;
      n_checks++; if (k !== exp_k) $display("FAIL rand_latency %0d/%0d: got %0d expected %0d", a, b, k, exp_k); else n_pass++;
      n_checks++; if (uo_out !== model(a, b))
        $display("FAIL rand_result %0d/%0d: got %h expected %h", a, b, uo_out, model(a, b));
      else n_pass++;
      n_checks++; if (uio_out[3] !== (b == 0))
        $display("FAIL rand_dbz %0d/%0d: got %b expected %b", a, b, uio_out[3], (b == 0));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_edges;
    test_div_zero;
    test_ignore_start;
    test_reset_mid;
    test_done_width;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
